// File: rtl/irq_gateway_pkg.sv
// Shared types and constants for the interrupt gateway: per-source state
// encoding, register offsets and the byte-enable expansion helper.
package irq_gateway_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_INSVC = 2'd2
    } src_state_e;

    localparam logic [1:0] REG_MODE  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_INSVC = 2'd2;
    localparam logic [1:0] REG_ZERO  = 2'd3;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/irq_gateway_if.sv
// Register-bus bundle of the interrupt gateway (request/response handshake).
interface irq_gateway_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output rvalid, rdata);
endinterface

// File: rtl/irq_gateway_src.sv
// One interrupt source: level/edge qualification, saturating edge counter
// and the IDLE/PEND/INSVC service state machine.
module irq_gateway_src
    import irq_gateway_pkg::*;
#(
    parameter int MAX_PENDING = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic s_i,
    input  logic mode_i,
    input  logic mode_chg_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic irq_req_o,
    output logic pend_o,
    output logic insvc_o
);

    localparam int CW = (MAX_PENDING < 1) ? 1 : $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    src_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          prev_q;
    logic          irq_q;

    logic          edge_s;
    logic          start_s;
    logic          resume_s;
    logic [CW-1:0] cnt_edge_s;

    // Edge qualification; an edge arriving with a completion is counted first.
    always_comb begin
        edge_s  = mode_i & s_i & ~prev_q;
        start_s = mode_i ? edge_s : s_i;
        if (edge_s && (state_q != ST_IDLE) && (cnt_q < CNT_MAX)) begin
            cnt_edge_s = cnt_q + CNT_ONE;
        end else begin
            cnt_edge_s = cnt_q;
        end
        resume_s = mode_i ? (cnt_edge_s != {CW{1'b0}}) : s_i;
    end

    // Service state machine, counter and registered request output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            prev_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            prev_q <= s_i;
            cnt_q  <= mode_chg_i ? {CW{1'b0}} : cnt_edge_s;
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q <= ST_PEND;
                        irq_q   <= 1'b1;
                    end else begin
                        irq_q   <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (claim_i) begin
                        state_q <= ST_INSVC;
                        irq_q   <= 1'b0;
                    end else begin
                        irq_q   <= 1'b1;
                    end
                end
                ST_INSVC: begin
                    if (complete_i && resume_s) begin
                        state_q <= ST_PEND;
                        irq_q   <= 1'b1;
                        if (mode_i && !mode_chg_i) begin
                            cnt_q <= cnt_edge_s - CNT_ONE;
                        end
                    end else if (complete_i) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end else begin
                        irq_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o = irq_q;
    assign pend_o    = (state_q == ST_PEND);
    assign insvc_o   = (state_q == ST_INSVC);

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway top: input synchroniser, MODE/PEND/INSVC register file
// and claim/complete decode feeding one irq_gateway_src per source.
module irq_gateway
    import irq_gateway_pkg::*;
#(
    parameter int SOURCES     = 32,
    parameter int MAX_PENDING = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    input  logic [SOURCES-1:0] irq_sources_i,
    input  logic               claim_valid_i,
    input  logic [4:0]         claim_id_i,
    input  logic               complete_valid_i,
    input  logic [4:0]         complete_id_i,
    output logic [SOURCES-1:0] irq_req_o
);

    logic [SOURCES-1:0] s_s;
    logic [SOURCES-1:0] mode_q;
    logic [SOURCES-1:0] mode_d;
    logic [SOURCES-1:0] mode_chg_s;
    logic [SOURCES-1:0] pend_s;
    logic [SOURCES-1:0] insvc_s;
    logic [SOURCES-1:0] claim_s;
    logic [SOURCES-1:0] complete_s;
    logic [31:0]        mode_ext_s;
    logic [31:0]        pend_ext_s;
    logic [31:0]        insvc_ext_s;
    logic [31:0]        wr_mode_s;
    logic [31:0]        rdata_d;
    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic               mode_wr_s;
    logic               unused_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s_s = irq_sources_i;
        end else begin : g_sync
            logic [SOURCES-1:0] sync_q [SYNC_STAGES];

            // Synchroniser chain for the asynchronous device lines.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= {SOURCES{1'b0}};
                    end
                end else begin
                    sync_q[0] <= irq_sources_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Register-file decode: byte-masked MODE update and read mux.
    always_comb begin
        mode_ext_s                 = 32'h0;
        mode_ext_s[SOURCES-1:0]    = mode_q;
        pend_ext_s                 = 32'h0;
        pend_ext_s[SOURCES-1:0]    = pend_s;
        insvc_ext_s                = 32'h0;
        insvc_ext_s[SOURCES-1:0]   = insvc_s;
        wr_mode_s = (mode_ext_s & ~be_mask(be_i)) | (wdata_i & be_mask(be_i));
        mode_wr_s = req_i & we_i & (addr_i[3:2] == REG_MODE);
        if (mode_wr_s) begin
            mode_d = wr_mode_s[SOURCES-1:0];
        end else begin
            mode_d = mode_q;
        end
        if (req_i && !we_i) begin
            case (addr_i[3:2])
                REG_MODE:  rdata_d = mode_ext_s;
                REG_PEND:  rdata_d = pend_ext_s;
                REG_INSVC: rdata_d = insvc_ext_s;
                REG_ZERO:  rdata_d = 32'h0;
                default:   rdata_d = 32'h0;
            endcase
        end else begin
            rdata_d = 32'h0;
        end
    end

    assign mode_chg_s = mode_d ^ mode_q;
    assign unused_s   = ^{addr_i[31:4], addr_i[1:0]};

    // MODE register and the one-cycle bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q   <= {SOURCES{1'b0}};
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            mode_q   <= mode_d;
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    // Out-of-range IDs match no source index and are dropped here.
    for (genvar i = 0; i < SOURCES; i++) begin : g_src
        assign claim_s[i]    = claim_valid_i & (claim_id_i == 5'(i));
        assign complete_s[i] = complete_valid_i & (complete_id_i == 5'(i));

        irq_gateway_src #(
            .MAX_PENDING (MAX_PENDING)
        ) u_src (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .s_i        (s_s[i]),
            .mode_i     (mode_q[i]),
            .mode_chg_i (mode_chg_s[i]),
            .claim_i    (claim_s[i]),
            .complete_i (complete_s[i]),
            .irq_req_o  (irq_req_o[i]),
            .pend_o     (pend_s[i]),
            .insvc_o    (insvc_s[i])
        );
    end

endmodule

// File: tb/tb_irq_gateway.sv
// Directed bench for irq_gateway: bus responses go through an expected-value
// queue, request lines are compared against hand-derived constants.
module tb_irq_gateway;
    import irq_gateway_pkg::*;

    localparam logic [31:0] A_MODE  = 32'h0;
    localparam logic [31:0] A_PEND  = 32'h4;
    localparam logic [31:0] A_INSVC = 32'h8;
    localparam logic [31:0] A_ZERO  = 32'hC;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] irq_src;
    logic        claim_v;
    logic [4:0]  claim_id;
    logic        comp_v;
    logic [4:0]  comp_id;
    logic [31:0] irq_req;
    logic [5:0]  big_id;
    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    irq_gateway_if bus_if ();

    irq_gateway #(
        .SOURCES     (32),
        .MAX_PENDING (15),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_i            (bus_if.req),
        .addr_i           (bus_if.addr),
        .we_i             (bus_if.we),
        .be_i             (bus_if.be),
        .wdata_i          (bus_if.wdata),
        .rvalid_o         (bus_if.rvalid),
        .rdata_o          (bus_if.rdata),
        .irq_sources_i    (irq_src),
        .claim_valid_i    (claim_v),
        .claim_id_i       (claim_id),
        .complete_valid_i (comp_v),
        .complete_id_i    (comp_id),
        .irq_req_o        (irq_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic resp_check(input string tag);
        check({tag, "_rvalid"}, {31'h0, bus_if.rvalid}, 32'h1);
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end else begin
            check(tag, bus_if.rdata, exp_q.pop_front());
        end
    endtask

    task automatic bus_write(input string tag, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = addr;
        bus_if.be    = be;
        bus_if.wdata = data;
        exp_q.push_back(32'h0);
        tick(1);
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        resp_check(tag);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = addr;
        bus_if.be   = 4'h0;
        exp_q.push_back(exp);
        tick(1);
        bus_if.req  = 1'b0;
        resp_check(tag);
    endtask

    task automatic strobe(input logic cv, input logic [4:0] cid, input logic pv, input logic [4:0] pid);
        claim_v  = cv;
        claim_id = cid;
        comp_v   = pv;
        comp_id  = pid;
        tick(1);
        claim_v  = 1'b0;
        comp_v   = 1'b0;
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        tick(1);
        irq_src[idx] = 1'b0;
        tick(1);
    endtask

    // Directed scenario sequence.
    initial begin
        rst_ni       = 1'b0;
        irq_src      = 32'h0;
        claim_v      = 1'b0;
        claim_id     = 5'd0;
        comp_v       = 1'b0;
        comp_id      = 5'd0;
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 32'h0;
        bus_if.be    = 4'h0;
        bus_if.wdata = 32'h0;
        big_id       = 6'd40;

        tick(2);
        check("rst_irq", irq_req, 32'h0);
        check("rst_rvalid", {31'h0, bus_if.rvalid}, 32'h0);
        check("rst_rdata", bus_if.rdata, 32'h0);
        rst_ni = 1'b1;
        tick(1);
        check("post_rst_irq", irq_req, 32'h0);

        // Level source 3: latency, claim, complete with line still high.
        irq_src[3] = 1'b1;
        tick(2);
        check("s1_lat_early", irq_req, 32'h0);
        tick(1);
        check("s1_lat", irq_req, 32'h8);
        bus_read("s1_pend", A_PEND, 32'h8);
        strobe(1'b1, 5'd3, 1'b0, 5'd0);
        check("s1_claim", irq_req, 32'h0);
        bus_read("s1_insvc", A_INSVC, 32'h8);
        strobe(1'b0, 5'd0, 1'b1, 5'd3);
        check("s1_complete_high", irq_req, 32'h8);
        irq_src[3] = 1'b0;
        tick(2);
        strobe(1'b1, 5'd3, 1'b0, 5'd0);
        strobe(1'b0, 5'd0, 1'b1, 5'd3);
        check("s1_complete_low", irq_req, 32'h0);
        bus_read("s1_idle", A_INSVC, 32'h0);

        // Edge mode on sources 5, 6 and 9.
        bus_write("s2_wr_mode", A_MODE, 4'hF, 32'h0000_0260);
        bus_read("s2_rd_mode", A_MODE, 32'h0000_0260);
        pulse(5);
        tick(1);
        check("s2_pend", irq_req, 32'h20);
        strobe(1'b1, 5'd5, 1'b0, 5'd0);
        for (int p = 0; p < 4; p++) pulse(5);
        tick(2);
        check("s2_insvc_quiet", irq_req, 32'h0);
        for (int r = 0; r < 4; r++) begin
            strobe(1'b0, 5'd0, 1'b1, 5'd5);
            check($sformatf("s2_round%0d_pend", r), irq_req, 32'h20);
            strobe(1'b1, 5'd5, 1'b0, 5'd0);
            check($sformatf("s2_round%0d_claim", r), irq_req, 32'h0);
        end
        strobe(1'b0, 5'd0, 1'b1, 5'd5);
        check("s2_final_idle", irq_req, 32'h0);
        bus_read("s2_pend_rd", A_PEND, 32'h0);
        bus_read("s2_insvc_rd", A_INSVC, 32'h0);

        // Counter saturation on source 6.
        pulse(6);
        tick(1);
        check("s3_pend", irq_req, 32'h40);
        strobe(1'b1, 5'd6, 1'b0, 5'd0);
        for (int p = 0; p < 20; p++) pulse(6);
        tick(2);
        for (int r = 0; r < 15; r++) begin
            strobe(1'b0, 5'd0, 1'b1, 5'd6);
            check($sformatf("s3_round%0d_pend", r), irq_req, 32'h40);
            strobe(1'b1, 5'd6, 1'b0, 5'd0);
            check($sformatf("s3_round%0d_claim", r), irq_req, 32'h0);
        end
        strobe(1'b0, 5'd0, 1'b1, 5'd6);
        check("s3_final_idle", irq_req, 32'h0);
        bus_read("s3_insvc_rd", A_INSVC, 32'h0);

        // Ignored claims: idle source 7 and out-of-range id 40 on a 5-bit port.
        irq_src[2] = 1'b1;
        tick(3);
        check("s4_src2_pend", irq_req, 32'h4);
        strobe(1'b1, 5'd7, 1'b0, 5'd0);
        strobe(1'b1, big_id[4:0], 1'b0, 5'd0);
        check("s4_irq_same", irq_req, 32'h4);
        bus_read("s4_pend_rd", A_PEND, 32'h4);
        bus_read("s4_insvc_rd", A_INSVC, 32'h0);

        // Same-cycle claim 2 / complete 9, then edge coincident with complete.
        pulse(9);
        tick(1);
        check("s5_src9_pend", irq_req, 32'h204);
        strobe(1'b1, 5'd9, 1'b0, 5'd0);
        check("s5_src9_claim", irq_req, 32'h4);
        strobe(1'b1, 5'd2, 1'b1, 5'd9);
        check("s5_dual_irq", irq_req, 32'h0);
        bus_read("s5_dual_insvc", A_INSVC, 32'h4);
        bus_read("s5_dual_pend", A_PEND, 32'h0);
        pulse(9);
        tick(1);
        strobe(1'b1, 5'd9, 1'b0, 5'd0);
        check("s5_src9_insvc", irq_req, 32'h0);
        pulse(9);
        strobe(1'b0, 5'd0, 1'b1, 5'd9);
        check("s5_coincident", irq_req, 32'h200);
        bus_read("s5_coinc_pend", A_PEND, 32'h200);
        strobe(1'b1, 5'd9, 1'b0, 5'd0);
        strobe(1'b0, 5'd0, 1'b1, 5'd9);
        check("s5_src9_done", irq_req, 32'h0);
        bus_read("s5_insvc_rd", A_INSVC, 32'h4);

        // Byte-enabled MODE write, then reset in the middle of service.
        bus_write("s6_clr_mode", A_MODE, 4'hF, 32'h0);
        bus_write("s6_wr_be0", A_MODE, 4'b0001, 32'hAAAA_AAFF);
        bus_read("s6_rd_mode", A_MODE, 32'h0000_00FF);
        bus_read("s6_rd_zero", A_ZERO, 32'h0);
        pulse(1);
        tick(1);
        strobe(1'b1, 5'd1, 1'b0, 5'd0);
        pulse(4);
        tick(1);
        check("s6_src4_pend", irq_req, 32'h10);
        bus_read("s6_insvc_rd", A_INSVC, 32'h6);
        irq_src[2] = 1'b0;
        rst_ni     = 1'b0;
        #1;
        check("s6_async_irq", irq_req, 32'h0);
        check("s6_async_rvalid", {31'h0, bus_if.rvalid}, 32'h0);
        check("s6_async_rdata", bus_if.rdata, 32'h0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        check("s6_post_rst_irq", irq_req, 32'h0);
        bus_read("s6_mode_rst", A_MODE, 32'h0);
        bus_read("s6_pend_rst", A_PEND, 32'h0);
        strobe(1'b0, 5'd0, 1'b1, 5'd1);
        bus_read("s6_insvc_rst", A_INSVC, 32'h0);
        check("s6_final_irq", irq_req, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/irq_gateway.md
IRQ_GATEWAY -- requirements
Module: irq_gateway

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SOURCES  32  number of interrupt sources, 1..32
  MAX_PENDING  15  saturation value of each per-source edge counter
  SYNC_STAGES  2  input synchroniser depth, 0 = bypass
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_i  in  1  single clock
  rst_ni  in  1  asynchronous, active-low reset
  req_i  in  1  bus request
  addr_i  in  32  bus byte address
  we_i  in  1  bus write enable
  be_i  in  4  byte enables
  wdata_i  in  32  write data
  rvalid_o  out  1  response valid
  rdata_o  out  32  read data
  irq_sources_i  in  SOURCES  raw device interrupt lines, asynchronous
  claim_valid_i  in  1  PLIC claim strobe
  claim_id_i  in  5  ID of the source being claimed
  complete_valid_i  in  1  PLIC complete strobe
  complete_id_i  in  5  ID of the source being completed
  irq_req_o  out  SOURCES  gated request to the PLIC pending logic

Function
REQ-003 Each irq_sources_i bit SHALL pass through SYNC_STAGES flops; all further logic SHALL use the synchronised value s[i].
REQ-004 Each source SHALL run an FSM with states IDLE, PEND and INSVC; irq_req_o[i] SHALL be 1 only in PEND.
REQ-005 Level mode (mode[i]=0): IDLE->PEND when s[i]=1; PEND->INSVC on claim of i; INSVC->PEND on complete of i if s[i]=1, otherwise INSVC->IDLE.
REQ-006 Edge mode (mode[i]=1): a rising edge is s[i]=1 while the previous s[i]=0; IDLE->PEND on an edge.
REQ-007 Edge mode: an edge in PEND or INSVC SHALL increment cnt[i], saturating at MAX_PENDING; on complete in INSVC with cnt[i]>0 the FSM SHALL go to PEND and decrement cnt[i], otherwise go to IDLE.
REQ-008 A claim with id >= SOURCES, or for a source not in PEND, SHALL be ignored; the same rule SHALL apply to a complete for a source not in INSVC.
REQ-009 A claim and a complete in the same cycle SHALL both take effect on their respective sources; if they name the same source, only the transition valid for the current state SHALL apply.
REQ-010 An edge in the same cycle as the complete of the same source SHALL be counted before the completion decision, so the source SHALL go to PEND.
REQ-011 All state transitions SHALL be visible on irq_req_o one cycle after the causing input; total latency from irq_sources_i to irq_req_o SHALL be SYNC_STAGES+1 cycles.
REQ-012 Register map (addr_i[3:2]):
  0: MODE, read/write, one bit per source
  1: PEND status, read-only
  2: INSVC status, read-only
  3: reads 0
REQ-013 Bus writes SHALL respect be_i per byte; bits at positions >= SOURCES SHALL read 0.
REQ-014 A write that changes mode[i] SHALL force cnt[i] to 0 and SHALL NOT change FSM state.
REQ-015 rvalid_o SHALL be asserted exactly one cycle after every req_i; rdata_o SHALL be registered and valid with rvalid_o, and SHALL be 0 for writes.

Reset
REQ-016 On rst_ni low, asynchronously, the block SHALL clear:
  all FSMs to IDLE
  cnt, mode and synchroniser flops
  irq_req_o, rvalid_o and rdata_o
REQ-017 Reset mid-service SHALL discard all in-flight claims; the first cycle after reset SHALL see irq_req_o=0.

Structure
REQ-018 Package irq_gateway_pkg SHALL hold the state enum (IDLE/PEND/INSVC) and the register offset constants.
REQ-019 Sub-module irq_gateway_src SHALL implement one source's FSM, edge detect and counter, instantiated SOURCES times via generate.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
  1. Level, src 3 high: irq_req_o[3]=1 after 3 cycles; claim 3 -> 0 next cycle; complete 3 with line still high -> 1 next cycle.
  2. Edge, src 5, 4 pulses during INSVC: 4 further PEND/claim/complete rounds, then IDLE.
  3. Edge, 20 pulses during INSVC: cnt saturates at 15; exactly 15 extra rounds follow.
  4. Claim id 7 while src 7 IDLE, and claim id 40: no state change; PEND/INSVC readback unchanged.
  5. Same-cycle claim 2 and complete 9 -> src 2 INSVC and src 9 IDLE; edge on 9 coincident with complete 9 -> src 9 PEND.
  6. Write MODE=0x0000_00FF with be_i=0001 -> reads 0xFF; rst_ni pulsed while src 1 INSVC -> all FSMs IDLE, irq_req_o=0.
